neuron_accumulator: RTL and testbench

Downstream stage of the combinational `neuron` product/bias unit. It takes the stream of signed 8-bit Q1.7 per-input terms that `neuron` produces, sums `N_TERMS` of them in a wide accumulator, and clamps the total back to 8-bit Q1.7. The result is presented on a valid/ready output to the next layer. Bias is applied upstream: the driver sets `b` non-zero only on the first term of each neuron evaluation.

---
 rtl/neuron_accumulator.sv | 156 +++++++++++++++
 tb/tb_neuron_accumulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// ---------------------------------------------------------------------------
// neuron_accumulator
//
// Sums N_TERMS signed Q1.7 terms coming out of the combinational neuron
// product/bias unit. The total is kept in an ACC_W-bit accumulator and then
// clamped back to 8-bit Q1.7. The finished result is held on a valid/ready
// output until the next layer takes it.
//
// Parameters:
//   N_TERMS    terms summed per result (2..256)
//   ACC_W      accumulator width, at least 8 + clog2(N_TERMS)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data carries a term
//   in_ready   block accepts a term this cycle
//   in_data    signed Q1.7 term
//   out_valid  out_data holds a finished result
//   out_ready  consumer takes the result this cycle
//   out_data   signed Q1.7 clamped sum
//   out_sat    result was clamped to +127 or -128
//
// Build option:
//   NEURON_ACC_RELU_EN  when defined, negative clamped results output 8'h00.
//                       out_sat still reports whether the clamp was applied.
// ---------------------------------------------------------------------------
module neuron_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sat
);

    localparam int CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [7:0]                out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0]   termExt;
    logic signed [ACC_W-1:0]   sum;
    logic                      satHigh;
    logic                      satLow;
    logic [7:0]                clampVal;
    logic [7:0]                resultVal;
    logic                      accept;
    logic                      lastTerm;

    // in_ready decodes the state directly; it is also forced low while reset
    // is asserted so nothing appears to be accepted during reset.
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign accept    = in_valid && in_ready;
    assign lastTerm  = (cnt_q == LAST_CNT);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Running sum including the current term, and its saturation to Q1.7.
    // The accumulator is wide enough that this sum never wraps, so the clamp
    // only has to compare against the 8-bit signed limits.
    always_comb begin
        termExt  = {{(ACC_W-8){in_data[7]}}, in_data};
        sum      = acc_q + termExt;
        satHigh  = (sum > SAT_MAX);
        satLow   = (sum < SAT_MIN);
        clampVal = sum[7:0];
        if (satHigh) begin
            clampVal = 8'h7F;
        end else if (satLow) begin
            clampVal = 8'h80;
        end
`ifdef NEURON_ACC_RELU_EN
        resultVal = clampVal[7] ? 8'h00 : clampVal;
`else
        resultVal = clampVal;
`endif
    end

    // Next-state logic: ACCUM gathers terms until the last one arrives, then
    // the clamped result is latched and HOLD waits for the consumer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (lastTerm) begin
                        out_data_d  = resultVal;
                        out_sat_d   = satHigh || satLow;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State registers; reset discards any partial sum and pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= 8'h00;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// ---------------------------------------------------------------------------
// tb_neuron_accumulator
//
// Bench for neuron_accumulator with N_TERMS = 4. Term sets come from a table;
// each set pushes its expected result into a queue and a monitor pops and
// compares whenever the DUT hands a result over. Hand-written sequences cover
// backpressure and reset in the middle of a set.
// Honors NEURON_ACC_RELU_EN for the expected values of negative results.
// ---------------------------------------------------------------------------
module tb_neuron_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sat;

    int errors;
    int checks;

    typedef struct {
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] t2;
        logic [7:0] t3;
        logic [7:0] expData;
        logic       expSat;
        bit         alt;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
    } res_t;

    vec_t vecs[8];
    res_t expQ[$];

    neuron_accumulator #(
        .N_TERMS(4),
        .ACC_W  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    // 10 ns clock, inputs change on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything below stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef NEURON_ACC_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    function automatic vec_t mkVec(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] c, input logic [7:0] d,
                                   input logic [7:0] e, input logic s,
                                   input bit alt);
        vec_t v;
        v.t0 = a;
        v.t1 = b;
        v.t2 = c;
        v.t3 = d;
        v.expData = relu(e);
        v.expSat = s;
        v.alt = alt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one term and hold it until the DUT can take it; the accept
    // happens on the rising edge after in_ready is seen high.
    task automatic driveTerm(input logic [7:0] t);
        int waitCnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = t;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_wait: got 0 expected 1");
        end
    endtask

    // Feed a full set of four terms, optionally with an idle beat (carrying
    // junk data) between terms. The expected result is queued up front.
    task automatic applyStimulus(input vec_t v, input string name);
        logic [7:0] terms[4];
        terms[0] = v.t0;
        terms[1] = v.t1;
        terms[2] = v.t2;
        terms[3] = v.t3;
        expQ.push_back({v.expData, v.expSat});
        for (int i = 0; i < 4; i++) begin
            if (v.alt && i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'hAA;
            end
            driveTerm(terms[i]);
        end
        checkOutput({name, "_valid_before"}, {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        checkOutput({name, "_valid_latency"}, {7'd0, out_valid}, 8'd1);
    endtask

    // Scoreboard side: compare whenever a result is handed over
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got %0h expected none", out_data);
            end else begin
                res_t r;
                r = expQ.pop_front();
                checkOutput("sb_data", out_data, r.d);
                checkOutput("sb_sat", {7'd0, out_sat}, {7'd0, r.s});
            end
        end
    end

    initial begin
        int waitCnt;
        vec_t v;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        vecs[0] = mkVec(8'd10, 8'd20, 8'd30, 8'd40, 8'd100, 1'b0, 1'b0);
        vecs[1] = mkVec(8'd100, 8'd100, 8'd100, 8'd100, 8'h7F, 1'b1, 1'b0);
        vecs[2] = mkVec(8'(-100), 8'(-100), 8'(-100), 8'(-100), 8'h80, 1'b1, 1'b0);
        vecs[3] = mkVec(8'd5, 8'(-3), 8'(-2), 8'd0, 8'h00, 1'b0, 1'b0);
        vecs[4] = mkVec(8'd127, 8'd1, 8'd0, 8'd0, 8'h7F, 1'b1, 1'b0);
        vecs[5] = mkVec(8'd7, 8'd7, 8'd7, 8'd7, 8'd28, 1'b0, 1'b1);
        vecs[6] = mkVec(8'(-50), 8'd20, 8'(-10), 8'd3, 8'hDB, 1'b0, 1'b0);
        vecs[7] = mkVec(8'h80, 8'hFF, 8'd0, 8'd0, 8'h80, 1'b1, 1'b1);

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {7'd0, in_ready}, 8'd0);
        checkOutput("rst_out_valid", {7'd0, out_valid}, 8'd0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_out_sat", {7'd0, out_sat}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", {7'd0, in_ready}, 8'd1);

        // Table-driven sets, back to back with out_ready high
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, no terms absorbed while in HOLD
        @(negedge clk);
        out_ready = 1'b0;
        v = mkVec(8'd10, 8'd20, 8'd30, 8'd40, 8'd100, 1'b0, 1'b0);
        applyStimulus(v, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd55;
            @(negedge clk);
            checkOutput("bp_in_ready", {7'd0, in_ready}, 8'd0);
            checkOutput("bp_out_valid", {7'd0, out_valid}, 8'd1);
            checkOutput("bp_out_data", out_data, 8'd100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_resume_ready", {7'd0, in_ready}, 8'd1);
        checkOutput("bp_resume_valid", {7'd0, out_valid}, 8'd0);
        v = mkVec(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 1'b0, 1'b0);
        applyStimulus(v, "bp_next");

        // Reset after two terms discards the partial sum
        driveTerm(8'd50);
        driveTerm(8'd50);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready", {7'd0, in_ready}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_out_valid", {7'd0, out_valid}, 8'd0);
        v = mkVec(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 1'b0, 1'b0);
        applyStimulus(v, "midrst");

        // Let the last result drain
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
